// File: rtl/hermes_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package : HermesPkg
// Hermes flit definitions and memory-responder command codes.
// Rev     : 1.0
// ============================================================================
package HermesPkg;

  localparam int FLIT_W = 32;

  typedef logic [FLIT_W-1:0] flit_t;

  localparam flit_t MEM_CMD_WRITE  = 32'd1;
  localparam flit_t MEM_CMD_READ   = 32'd2;
  localparam flit_t MEM_CMD_RREPLY = 32'd3;

  // size counts the flits after the size flit: cmd, src, addr, payload
  function automatic logic req_is_valid(input flit_t cmd, input flit_t size);
    return ((cmd == MEM_CMD_WRITE) && (size >= 32'd3)) ||
           ((cmd == MEM_CMD_READ)  && (size == 32'd4));
  endfunction

endpackage

`default_nettype wire

// File: rtl/hermes_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : hermes_mem_responder_if
// Hermes rx/tx edge-port links plus the synchronous memory port.
// Rev       : 1.0
// ============================================================================
interface hermes_mem_responder_if #(
  parameter int MEM_AW = 24
);

  logic              rx_i;
  logic              credit_o;
  logic [31:0]       data_i;

  logic              tx_o;
  logic              credit_i;
  logic [31:0]       data_o;

  logic              mem_en_o;
  logic [3:0]        mem_we_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;
  logic [31:0]       mem_data_i;

  logic              err_o;

  modport slave (
    input  rx_i, data_i, credit_i, mem_data_i,
    output credit_o, tx_o, data_o, mem_en_o, mem_we_o, mem_addr_o,
           mem_data_o, err_o
  );

  modport master (
    output rx_i, data_i, credit_i, mem_data_i,
    input  credit_o, tx_o, data_o, mem_en_o, mem_we_o, mem_addr_o,
           mem_data_o, err_o
  );

endinterface

`default_nettype wire

// File: rtl/hermes_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : hermes_mem_responder
// Hermes NoC endpoint serving WRITE/READ packets against a synchronous memory.
// Rev    : 1.0
// ============================================================================
module hermes_mem_responder
  import HermesPkg::*;
#(
  parameter logic [15:0] ADDRESS = 16'h0000,
  parameter int          MEM_AW  = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  hermes_mem_responder_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, SIZE, CMD, SRC, ADDR, WDATA, RLEN,
    RHDR, RSIZE, RCMD, RSRC, RREQ, RDATA, DRAIN
  } state_t;

  localparam logic [MEM_AW-1:0] c_WORD_STEP = MEM_AW'(4);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [31:0]       r_cnt;
  logic [15:0]       r_src;
  logic [MEM_AW-1:0] r_addr;
  logic              r_is_write;
  logic [31:0]       r_rdata;
  logic              r_rd_held;
  logic              r_err;

  logic              w_rx_state;
  logic              w_tx_state;
  logic              w_credit;
  logic              w_rx_acc;
  logic              w_tx_acc;
  logic              w_err_set;
  logic [31:0]       w_data_o;
  logic              w_mem_en;
  logic [3:0]        w_mem_we;
  logic [31:0]       w_mem_data;

  assign w_rx_state = (r_state inside {IDLE, SIZE, CMD, SRC, ADDR, WDATA, RLEN, DRAIN});
  assign w_tx_state = (r_state inside {RHDR, RSIZE, RCMD, RSRC, RDATA});
  assign w_credit   = rst_ni & w_rx_state;
  assign w_rx_acc   = bus.rx_i & w_credit;
  assign w_tx_acc   = w_tx_state & bus.credit_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    w_data_o    = '0;
    w_mem_en    = 1'b0;
    w_mem_we    = 4'h0;
    w_mem_data  = '0;
    unique case (r_state)
      IDLE:  if (w_rx_acc) w_state_nxt = SIZE;
      SIZE: begin
        if (w_rx_acc) begin
          if (bus.data_i == 32'd0) begin
            w_err_set   = 1'b1;
            w_state_nxt = IDLE;
          end else if (bus.data_i == 32'd1) begin
            w_err_set   = 1'b1;
            w_state_nxt = DRAIN;
          end else begin
            w_state_nxt = CMD;
          end
        end
      end
      CMD: begin
        if (w_rx_acc) begin
          if (req_is_valid(bus.data_i, r_cnt)) begin
            w_state_nxt = SRC;
          end else begin
            w_err_set   = 1'b1;
            w_state_nxt = DRAIN;
          end
        end
      end
      SRC:   if (w_rx_acc) w_state_nxt = ADDR;
      ADDR: begin
        if (w_rx_acc) begin
          if (!r_is_write)          w_state_nxt = RLEN;
          else if (r_cnt == 32'd1)  w_state_nxt = IDLE;
          else                      w_state_nxt = WDATA;
        end
      end
      WDATA: begin
        w_mem_en   = w_rx_acc;
        w_mem_we   = w_rx_acc ? 4'hF : 4'h0;
        w_mem_data = w_rx_acc ? bus.data_i : 32'd0;
        if (w_rx_acc && (r_cnt == 32'd1)) w_state_nxt = IDLE;
      end
      DRAIN: if (w_rx_acc && (r_cnt == 32'd1)) w_state_nxt = IDLE;
      RLEN:  if (w_rx_acc) w_state_nxt = RHDR;
      RHDR: begin
        w_data_o = {16'h0000, r_src};
        if (w_tx_acc) w_state_nxt = RSIZE;
      end
      RSIZE: begin
        w_data_o = r_cnt + 32'd2;
        if (w_tx_acc) w_state_nxt = RCMD;
      end
      RCMD: begin
        w_data_o = MEM_CMD_RREPLY;
        if (w_tx_acc) w_state_nxt = RSRC;
      end
      RSRC: begin
        w_data_o = {16'h0000, ADDRESS};
        if (w_tx_acc) w_state_nxt = (r_cnt == 32'd0) ? IDLE : RREQ;
      end
      RREQ: begin
        w_mem_en    = 1'b1;
        w_state_nxt = RDATA;
      end
      RDATA: begin
        // First cycle shows the memory output directly, later cycles the held copy
        w_data_o = r_rd_held ? r_rdata : bus.mem_data_i;
        if (w_tx_acc) w_state_nxt = (r_cnt == 32'd1) ? IDLE : RREQ;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt      <= '0;
      r_src      <= '0;
      r_addr     <= '0;
      r_is_write <= 1'b0;
      r_rdata    <= '0;
      r_rd_held  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_err_set;
      unique case (r_state)
        SIZE: if (w_rx_acc) r_cnt <= bus.data_i;
        CMD: begin
          if (w_rx_acc) begin
            r_cnt      <= r_cnt - 32'd1;
            r_is_write <= (bus.data_i == MEM_CMD_WRITE);
          end
        end
        SRC: begin
          if (w_rx_acc) begin
            r_cnt <= r_cnt - 32'd1;
            r_src <= bus.data_i[15:0];
          end
        end
        ADDR: begin
          if (w_rx_acc) begin
            r_cnt  <= r_cnt - 32'd1;
            r_addr <= {bus.data_i[MEM_AW-1:2], 2'b00};
          end
        end
        WDATA: begin
          if (w_rx_acc) begin
            r_cnt  <= r_cnt - 32'd1;
            r_addr <= r_addr + c_WORD_STEP;
          end
        end
        DRAIN: if (w_rx_acc) r_cnt <= r_cnt - 32'd1;
        RLEN:  if (w_rx_acc) r_cnt <= bus.data_i;
        RDATA: begin
          if (!r_rd_held) begin
            r_rdata   <= bus.mem_data_i;
            r_rd_held <= 1'b1;
          end
          if (w_tx_acc) begin
            r_rd_held <= 1'b0;
            r_cnt     <= r_cnt - 32'd1;
            r_addr    <= r_addr + c_WORD_STEP;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.credit_o   = w_credit;
  assign bus.tx_o       = w_tx_state;
  assign bus.data_o     = w_data_o;
  assign bus.mem_en_o   = w_mem_en;
  assign bus.mem_we_o   = w_mem_we;
  assign bus.mem_addr_o = w_mem_en ? r_addr : '0;
  assign bus.mem_data_o = w_mem_data;
  assign bus.err_o      = r_err;

  logic w_unused_bits;
  assign w_unused_bits = ^{bus.data_i[31:16], bus.data_i[1:0]};

endmodule

`default_nettype wire

// File: doc/hermes_mem_responder.md
HERMES_MEM_RESPONDER -- requirements
Module: hermes_mem_responder

Interface
REQ-001 SHALL have parameter ADDRESS, default 16'h0000, meaning this node's Hermes address, placed in every reply packet's source flit.
REQ-002 SHALL have parameter MEM_AW, default 24, meaning the memory byte-address width.
REQ-003 SHALL have port clk_i  in  1  clock; one clock domain, all logic on the rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports rx_i in 1, credit_o out 1, data_i in 32, meaning the Hermes receive side from the mesh edge port.
REQ-006 SHALL have ports tx_o out 1, credit_i in 1, data_o out 32, meaning the Hermes transmit side to the mesh edge port.
REQ-007 SHALL have ports mem_en_o out 1, mem_we_o out 4, mem_addr_o out MEM_AW, mem_data_o out 32, mem_data_i in 32, meaning a synchronous memory whose read data is valid one cycle after mem_en_o with mem_we_o=0.
REQ-008 SHALL have port err_o  out  1, meaning a one-cycle pulse when a packet is rejected.

Function
REQ-009 SHALL transfer an rx flit only on a rising edge with rx_i=1 and credit_o=1, and a tx flit only on a rising edge with tx_o=1 and credit_i=1.
REQ-010 SHALL hold data_o and tx_o stable until the flit is accepted.
REQ-011 SHALL parse request flits in this order: header (ignored), size S (count of flits after size), cmd, src, addr, then payload.
REQ-012 SHALL use cmd 1 for WRITE, with payload = S-3 data words, and cmd 2 for READ, with payload = one flit holding word count N.
REQ-013 SHALL use FSM states IDLE, SIZE, CMD, SRC, ADDR, WDATA, RLEN, RHDR, RSIZE, RCMD, RSRC, RREQ, RDATA, DRAIN.
REQ-014 SHALL assert credit_o in states IDLE through WDATA, RLEN and DRAIN, and deassert it in every reply state.
REQ-015 WDATA: on each accepted flit, SHALL assert mem_en_o=1, mem_we_o=4'hF, mem_addr_o=current address and mem_data_o=data_i in the same cycle, then add 4 to the address.
REQ-016 WRITE with S=3 SHALL return from ADDR to IDLE with no memory access.
REQ-017 READ reply packet SHALL be: flit {16'h0, src[15:0]}, size N+2, cmd 3, ADDRESS, then N data words.
REQ-018 Each read word SHALL go RREQ (mem_en_o=1, mem_we_o=0, one cycle) -> RDATA (data registered from mem_data_i, tx_o=1 until accepted), giving at most 1 word per 2 cycles.
REQ-019 READ with N=0 SHALL send only the 4-flit reply, with size 2.
REQ-020 SHALL wrap address arithmetic modulo 2^MEM_AW and ignore address bits [1:0] (word-aligned).
REQ-021 For an unknown cmd, a WRITE with S<3, or a READ with S!=4, SHALL pulse err_o, consume the remaining flits in DRAIN and return to IDLE with no memory access.
REQ-022 SHALL use a 32-bit remaining-flit counter, with S=0 or 1 treated as REQ-021.
REQ-023 SHALL not accept a new request until the reply's last flit is accepted.
REQ-024 SHALL reset outputs to tx_o=0, credit_o=0, mem_en_o=0, mem_we_o=0, err_o=0, data_o/mem_addr_o/mem_data_o=0.

Reset
REQ-025 rst_ni low SHALL asynchronously force IDLE, clear all counters and registers, and abort any in-flight request or reply mid-packet.
REQ-026 SHALL assert credit_o only while rst_ni=1 and the state is IDLE or another receive state.

Structure
REQ-027 Command codes (MEM_CMD_WRITE=1, MEM_CMD_READ=2, MEM_CMD_RREPLY=3) SHALL reside in HermesPkg alongside the existing flit definitions.
REQ-028 The FSM state enum SHALL be local to the module.
REQ-029 SHALL need no sub-module; the block is a single FSM plus datapath registers.

Verification
REQ-030 WRITE: hdr, S=5, cmd 1, src 0x0101, addr 0x000100, data 0xAAAA0001, 0xAAAA0002 -> two writes at 0x100 and 0x104, no tx, back to IDLE.
REQ-031 READ: S=4, cmd 2, src 0x0203, addr 0x100, N=2 -> reply flits 0x0203, 4, 3, ADDRESS, 0xAAAA0001, 0xAAAA0002.
REQ-032 Backpressure: credit_i held low 5 cycles during RDATA -> data_o and tx_o stay stable, no extra mem_en_o, no flit lost.
REQ-033 Bad cmd 7 with S=6 -> err_o pulses once, 5 flits drained, no memory access, next valid request served.
REQ-034 Wrap: WRITE at addr 0xFFFFFC with 2 words -> writes at 0xFFFFFC then 0x000000.
REQ-035 Reset asserted mid-reply -> tx_o=0 and the FSM in IDLE immediately; after release, a fresh READ is served correctly.
